// File: rtl/multiplexer2to1_arbiter.sv
// rtl/multiplexer2to1_arbiter.sv - round-robin arbiter driving the select line of a shared 2-to-1 mux
module multiplexer2to1_arbiter #(
    parameter int MAX_HOLD_CYCLES = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] request_i,
    output logic [1:0] grant_o,
    output logic       selection_o,
    output logic       busy_o,
    output logic       grant_changed_o
);

    localparam int HW = $clog2(MAX_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    grant_q;
    logic          selection_q;
    logic          busy_q;
    logic          grant_changed_q;
    logic          last_granted_q;
    logic [HW-1:0] hold_count_q;

    logic enter_d;
    logic owner_d;
    logic idle_d;
    logic cur_owner;

    assign cur_owner = (state_q == GRANT1);

    // Arbitration decision for the coming edge: enter a new grant, drop to idle, or hold.
    always_comb begin
        enter_d = 1'b0;
        owner_d = 1'b0;
        idle_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request_i != 2'b00) begin
                    enter_d = 1'b1;
                    owner_d = (request_i == 2'b11) ? ~last_granted_q : request_i[1];
                end
            end
            GRANT0, GRANT1: begin
                if (!request_i[cur_owner]) begin
                    if (request_i[~cur_owner]) begin
                        enter_d = 1'b1;
                        owner_d = ~cur_owner;
                    end else begin
                        idle_d = 1'b1;
                    end
                end else if (request_i[~cur_owner] && hold_count_q == HOLD_LAST) begin
                    enter_d = 1'b1;
                    owner_d = ~cur_owner;
                end
            end
            default: idle_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            grant_q         <= 2'b00;
            selection_q     <= 1'b0;
            busy_q          <= 1'b0;
            grant_changed_q <= 1'b0;
            last_granted_q  <= 1'b1;
            hold_count_q    <= '0;
        end else if (enter_d) begin
            state_q         <= owner_d ? GRANT1 : GRANT0;
            grant_q         <= owner_d ? 2'b10 : 2'b01;
            selection_q     <= owner_d;
            busy_q          <= 1'b1;
            grant_changed_q <= 1'b1;
            last_granted_q  <= owner_d;
            hold_count_q    <= '0;
        end else if (idle_d) begin
            state_q         <= IDLE;
            grant_q         <= 2'b00;
            busy_q          <= 1'b0;
            grant_changed_q <= 1'b0;
            hold_count_q    <= '0;
        end else begin
            grant_changed_q <= 1'b0;
            // Saturate rather than wrap so an uncontested owner can be preempted immediately later.
            if (state_q != IDLE && hold_count_q != HOLD_LAST) begin
                hold_count_q <= hold_count_q + 1'b1;
            end
        end
    end

    assign grant_o         = grant_q;
    assign selection_o     = selection_q;
    assign busy_o          = busy_q;
    assign grant_changed_o = grant_changed_q;

endmodule

// File: tb/tb_multiplexer2to1_arbiter.sv
// tb/tb_multiplexer2to1_arbiter.sv - scoreboard bench for multiplexer2to1_arbiter
module tb_multiplexer2to1_arbiter;

    localparam int MAX = 8;

    logic       clock;
    logic       reset;
    logic [1:0] request;
    logic [1:0] grant;
    logic       selection;
    logic       busy;
    logic       grant_changed;

    typedef struct packed {
        logic [1:0] grant;
        logic       sel;
        logic       busy;
        logic       changed;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: who owns the mux, who owned it last, and how many cycles it has been visible.
    int   m_owner = -1;
    int   m_last = 1;
    int   m_tenure = 0;
    logic m_sel = 1'b0;

    multiplexer2to1_arbiter #(.MAX_HOLD_CYCLES(MAX)) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .request_i       (request),
        .grant_o         (grant),
        .selection_o     (selection),
        .busy_o          (busy),
        .grant_changed_o (grant_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_edge(input logic rst, input logic [1:0] req);
        int   nxt;
        logic changed;
        exp_t e;
        changed = 1'b0;
        if (rst) begin
            m_owner  = -1;
            m_last   = 1;
            m_tenure = 0;
            m_sel    = 1'b0;
        end else begin
            if (m_owner < 0) begin
                if (req == 2'b00)      nxt = -1;
                else if (req == 2'b01) nxt = 0;
                else if (req == 2'b10) nxt = 1;
                else                   nxt = 1 - m_last;
            end else begin
                if (!req[m_owner])                          nxt = req[1 - m_owner] ? 1 - m_owner : -1;
                else if (req[1 - m_owner] && m_tenure >= MAX) nxt = 1 - m_owner;
                else                                        nxt = m_owner;
            end
            changed = (nxt >= 0) && (nxt != m_owner);
            if (changed) begin
                m_tenure = 1;
                m_last   = nxt;
                m_sel    = (nxt == 1);
            end else if (nxt >= 0) begin
                m_tenure = m_tenure + 1;
            end else begin
                m_tenure = 0;
            end
            m_owner = nxt;
        end
        e.grant   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e.sel     = m_sel;
        e.busy    = (m_owner >= 0);
        e.changed = changed;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [1:0] req);
        @(negedge clock);
        reset   = rst;
        request = req;
        model_edge(rst, req);
    endtask

    task automatic repeat_step(input logic rst, input logic [1:0] req, input int n);
        for (int i = 0; i < n; i++) step(rst, req);
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if ({grant, selection, busy, grant_changed} !== e) begin
                tests_failed++;
                $display("FAIL cycle_outputs t=%0t req=%b: got grant=%b sel=%b busy=%b chg=%b, expected grant=%b sel=%b busy=%b chg=%b",
                         $time, request, grant, selection, busy, grant_changed,
                         e.grant, e.sel, e.busy, e.changed);
            end
        end
    end

    initial begin
        logic [1:0] r;
        reset   = 1'b1;
        request = 2'b00;
        repeat_step(1'b1, 2'b00, 2);
        // Tie after reset goes to requester 0, then contested alternation every MAX cycles.
        repeat_step(1'b0, 2'b11, 4 * MAX + 3);
        repeat_step(1'b1, 2'b00, 1);
        // Lone requester: no forced switch, single grant_changed pulse.
        repeat_step(1'b0, 2'b01, 20);
        // Direct handover 0 -> 1, release to idle, then tie resolves to 0.
        repeat_step(1'b0, 2'b10, 3);
        repeat_step(1'b0, 2'b00, 3);
        repeat_step(1'b0, 2'b11, 3);
        // Saturated owner gets preempted as soon as the other side asks.
        repeat_step(1'b0, 2'b01, 15);
        repeat_step(1'b0, 2'b11, 3);
        // Reset in the middle of GRANT1.
        repeat_step(1'b0, 2'b10, 4);
        repeat_step(1'b1, 2'b10, 1);
        repeat_step(1'b0, 2'b11, 3);
        // Randomized traffic with sticky requests and rare resets.
        r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = 2'($urandom_range(3));
            step(($urandom_range(199) == 0), r);
        end
        repeat (3) @(posedge clock);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
